// File: rtl/flappy_pkg.sv
// Shared encodings for the flappy-bird game scheduler: phase states,
// player modes and the countdown length.
package flappy_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic       MODE_SINGLE    = 1'b0;
   localparam logic       MODE_DOUBLE    = 1'b1;
   localparam logic [1:0] COUNTDOWN_SECS = 2'd3;

   // The datapath is held clear until play actually starts.
   function automatic logic clears_datapath(input state_t s);
      return (s == ST_IDLE) || (s == ST_READY);
   endfunction

   // Phases in which the tick prescaler is allowed to hold a non-zero phase.
   function automatic logic keeps_phase(input state_t s);
      return (s == ST_READY) || (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running game-tick prescaler: counts while run is high, freezes
// otherwise, and clr forces the phase back to zero.
module tick_prescaler #(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic raw_tick
);

   localparam int PC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);
   localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

   logic [PC_W-1:0] pc;

   assign raw_tick = (pc == PC_LAST);

   // Phase counter; clr outranks run, a frozen count keeps the tick phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= {PC_W{1'b0}};
      end else if (clr) begin
         pc <= {PC_W{1'b0}};
      end else if (run) begin
         if (raw_tick) begin
            pc <= {PC_W{1'b0}};
         end else begin
            pc <= pc + PC_ONE;
         end
      end else begin
         pc <= pc;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game-phase scheduler: phase FSM, gated game tick, datapath clear,
// player-mode latch and high-score tracking.
module game_sequencer
   import flappy_pkg::*;
#(
   parameter int TICK_DIV      = 10_000_000,
   parameter int TICKS_PER_SEC = 10,
   parameter int SCORE_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               btn_pause,
   input  logic               mode_sel,
   input  logic               fail,
   input  logic [SCORE_W-1:0] score,
   output logic               tick,
   output logic               game_clr,
   output logic [2:0]         state,
   output logic               mode,
   output logic [1:0]         countdown,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_record
);

   localparam int SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_SEC - 1);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

   state_t cur_state;
   state_t next_state;

   logic start_q;
   logic pause_q;
   logic start_rise;
   logic pause_rise;
   logic raw_tick;
   logic pc_run;
   logic pc_clr;

   logic [SEC_W-1:0] sec_cnt;

   logic go_ready;
   logic sec_step;
   logic sec_done;
   logic cd_clear;
   logic take_record;

   assign start_rise = btn_start & ~start_q;
   assign pause_rise = btn_pause & ~pause_q;

   assign pc_run = (cur_state == ST_READY) || (cur_state == ST_RUN);
   assign pc_clr = ~keeps_phase(cur_state) | go_ready;
   assign tick   = raw_tick & (cur_state == ST_RUN);
   assign state  = cur_state;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .run      (pc_run),
      .clr      (pc_clr),
      .raw_tick (raw_tick)
   );

   // Button edge registers start high so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q <= 1'b1;
         pause_q <= 1'b1;
      end else begin
         start_q <= btn_start;
         pause_q <= btn_pause;
      end
   end

   // Phase state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= ST_IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-phase decode and per-cycle datapath strobes.
   always_comb begin
      next_state  = cur_state;
      go_ready    = 1'b0;
      sec_step    = 1'b0;
      sec_done    = 1'b0;
      cd_clear    = 1'b0;
      take_record = 1'b0;
      case (cur_state)
         ST_IDLE: begin
            if (start_rise) begin
               next_state = ST_READY;
               go_ready   = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_READY: begin
            if (pause_rise) begin
               next_state = ST_IDLE;
               cd_clear   = 1'b1;
            end else if (raw_tick) begin
               if (sec_cnt == SEC_LAST) begin
                  sec_done = 1'b1;
                  if (countdown == 2'd1) begin
                     next_state = ST_RUN;
                  end else begin
                     next_state = ST_READY;
                  end
               end else begin
                  sec_step   = 1'b1;
                  next_state = ST_READY;
               end
            end else begin
               next_state = ST_READY;
            end
         end
         ST_RUN: begin
            if (fail) begin
               next_state  = ST_OVER;
               take_record = (score > high_score);
            end else if (pause_rise) begin
               next_state = ST_PAUSE;
            end else begin
               next_state = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (start_rise || pause_rise) begin
               next_state = ST_RUN;
            end else begin
               next_state = ST_PAUSE;
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               next_state = ST_READY;
               go_ready   = 1'b1;
            end else begin
               next_state = ST_OVER;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Mode latch, countdown seconds and high score; record check uses the score of the losing cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode       <= MODE_SINGLE;
         countdown  <= 2'd0;
         sec_cnt    <= {SEC_W{1'b0}};
         high_score <= {SCORE_W{1'b0}};
         new_record <= 1'b0;
         game_clr   <= 1'b1;
      end else begin
         game_clr <= clears_datapath(next_state);
         if (go_ready) begin
            mode       <= mode_sel;
            countdown  <= COUNTDOWN_SECS;
            sec_cnt    <= {SEC_W{1'b0}};
            new_record <= 1'b0;
         end else if (cd_clear) begin
            countdown <= 2'd0;
            sec_cnt   <= {SEC_W{1'b0}};
         end else if (sec_done) begin
            countdown <= countdown - 2'd1;
            sec_cnt   <= {SEC_W{1'b0}};
         end else if (sec_step) begin
            sec_cnt <= sec_cnt + SEC_ONE;
         end else begin
            sec_cnt <= sec_cnt;
         end
         if (take_record) begin
            high_score <= score;
            new_record <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with TICK_DIV=4, TICKS_PER_SEC=2.
module tb_game_sequencer;

   logic        clk;
   logic        rst;
   logic        btn_start;
   logic        btn_pause;
   logic        mode_sel;
   logic        fail;
   logic [15:0] score;
   logic        tick;
   logic        game_clr;
   logic [2:0]  state;
   logic        mode;
   logic [1:0]  countdown;
   logic [15:0] high_score;
   logic        new_record;

   int tests_run = 0;
   int tests_failed = 0;

   game_sequencer #(
      .TICK_DIV      (4),
      .TICKS_PER_SEC (2),
      .SCORE_W       (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_pause  (btn_pause),
      .mode_sel   (mode_sel),
      .fail       (fail),
      .score      (score),
      .tick       (tick),
      .game_clr   (game_clr),
      .state      (state),
      .mode       (mode),
      .countdown  (countdown),
      .high_score (high_score),
      .new_record (new_record)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; mode_sel = 1'b0;
      fail = 1'b0; score = 16'd0;
      step(2);
      tests_run++;
      if (state !== 3'd0 || game_clr !== 1'b1 || tick !== 1'b0 || mode !== 1'b0 ||
          countdown !== 2'd0 || high_score !== 16'd0 || new_record !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_values: state=%0d clr=%0d tick=%0d mode=%0d cd=%0d hs=%0d nr=%0d, want 0 1 0 0 0 0 0",
                  state, game_clr, tick, mode, countdown, high_score, new_record);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         tests_run++;
         if (state !== 3'd0 || game_clr !== 1'b1 || tick !== 1'b0 || high_score !== 16'd0) begin
            tests_failed++;
            $display("FAIL idle_hold cyc %0d: state=%0d clr=%0d tick=%0d hs=%0d, want 0 1 0 0",
                     i, state, game_clr, tick, high_score);
         end
      end
   endtask

   task automatic test_countdown_run();
      int ticks;
      mode_sel = 1'b1;
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
      tests_run++;
      if (state !== 3'd1 || mode !== 1'b1 || countdown !== 2'd3 || game_clr !== 1'b1) begin
         tests_failed++;
         $display("FAIL enter_ready: state=%0d mode=%0d cd=%0d clr=%0d, want 1 1 3 1",
                  state, mode, countdown, game_clr);
      end
      for (int i = 1; i <= 24; i++) begin
         step(1);
         tests_run++;
         if (tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_no_tick cyc %0d: tick=%0d, want 0", i, tick);
         end
         if (i == 7 || i == 8 || i == 16) begin
            tests_run++;
            if (countdown !== ((i == 7) ? 2'd3 : (i == 8) ? 2'd2 : 2'd1) || state !== 3'd1) begin
               tests_failed++;
               $display("FAIL countdown cyc %0d: cd=%0d state=%0d", i, countdown, state);
            end
         end
      end
      tests_run++;
      if (state !== 3'd2 || countdown !== 2'd0 || game_clr !== 1'b0) begin
         tests_failed++;
         $display("FAIL enter_run: state=%0d cd=%0d clr=%0d, want 2 0 0", state, countdown, game_clr);
      end
      ticks = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         if (tick === 1'b1) ticks++;
         tests_run++;
         if (tick !== ((i % 4) == 3) || game_clr !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_tick cyc %0d: tick=%0d clr=%0d, want %0d 0", i, tick, game_clr, (i % 4) == 3);
         end
      end
      tests_run++;
      if (ticks != 3) begin
         tests_failed++;
         $display("FAIL run_tick_count: got %0d, want 3", ticks);
      end
   endtask

   task automatic test_pause_resume();
      btn_pause = 1'b1;
      step(1);
      tests_run++;
      if (state !== 3'd3 || tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL enter_pause: state=%0d tick=%0d, want 3 0", state, tick);
      end
      btn_pause = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         tests_run++;
         if (state !== 3'd3 || tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_hold cyc %0d: state=%0d tick=%0d, want 3 0", i, state, tick);
         end
      end
      btn_start = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         btn_start = 1'b0;
         tests_run++;
         if (state !== 3'd2 || tick !== (i == 3)) begin
            tests_failed++;
            $display("FAIL resume cyc %0d: state=%0d tick=%0d, want 2 %0d", i, state, tick, i == 3);
         end
      end
   endtask

   task automatic test_record();
      fail = 1'b1; btn_pause = 1'b1; score = 16'd7;
      step(1);
      tests_run++;
      if (state !== 3'd4 || high_score !== 16'd7 || new_record !== 1'b1 || game_clr !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_record: state=%0d hs=%0d nr=%0d clr=%0d, want 4 7 1 0",
                  state, high_score, new_record, game_clr);
      end
      fail = 1'b0; btn_pause = 1'b0; mode_sel = 1'b0;
      step(1);
      btn_pause = 1'b1;
      step(1);
      btn_pause = 1'b0;
      tests_run++;
      if (state !== 3'd4 || new_record !== 1'b1) begin
         tests_failed++;
         $display("FAIL over_ignores_pause: state=%0d nr=%0d, want 4 1", state, new_record);
      end
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
      tests_run++;
      if (state !== 3'd1 || mode !== 1'b0 || countdown !== 2'd3 || new_record !== 1'b0 ||
          high_score !== 16'd7 || game_clr !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart: state=%0d mode=%0d cd=%0d nr=%0d hs=%0d clr=%0d, want 1 0 3 0 7 1",
                  state, mode, countdown, new_record, high_score, game_clr);
      end
      step(24);
      tests_run++;
      if (state !== 3'd2) begin
         tests_failed++;
         $display("FAIL rerun: state=%0d, want 2", state);
      end
      fail = 1'b1; score = 16'd7;
      step(1);
      fail = 1'b0;
      tests_run++;
      if (state !== 3'd4 || high_score !== 16'd7 || new_record !== 1'b0) begin
         tests_failed++;
         $display("FAIL equal_score: state=%0d hs=%0d nr=%0d, want 4 7 0", state, high_score, new_record);
      end
   endtask

   task automatic test_reset_in_pause();
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
      step(24);
      btn_pause = 1'b1;
      step(1);
      btn_pause = 1'b0;
      tests_run++;
      if (state !== 3'd3 || high_score !== 16'd7) begin
         tests_failed++;
         $display("FAIL pause_before_rst: state=%0d hs=%0d, want 3 7", state, high_score);
      end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      tests_run++;
      if (state !== 3'd0 || high_score !== 16'd0 || game_clr !== 1'b1 || mode !== 1'b0 ||
          new_record !== 1'b0 || countdown !== 2'd0) begin
         tests_failed++;
         $display("FAIL rst_in_pause: state=%0d hs=%0d clr=%0d mode=%0d nr=%0d cd=%0d, want 0 0 1 0 0 0",
                  state, high_score, game_clr, mode, new_record, countdown);
      end
   endtask

   task automatic test_held_start();
      btn_start = 1'b1; rst = 1'b1;
      step(2);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         tests_run++;
         if (state !== 3'd0) begin
            tests_failed++;
            $display("FAIL held_start cyc %0d: state=%0d, want 0", i, state);
         end
      end
      btn_start = 1'b0;
      step(1);
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
      tests_run++;
      if (state !== 3'd1 || countdown !== 2'd3) begin
         tests_failed++;
         $display("FAIL press_after_release: state=%0d cd=%0d, want 1 3", state, countdown);
      end
   endtask

   task automatic test_abort_ready();
      step(8);
      tests_run++;
      if (state !== 3'd1 || countdown !== 2'd2) begin
         tests_failed++;
         $display("FAIL abort_setup: state=%0d cd=%0d, want 1 2", state, countdown);
      end
      btn_pause = 1'b1; btn_start = 1'b1;
      step(1);
      btn_pause = 1'b0; btn_start = 1'b0;
      tests_run++;
      if (state !== 3'd0 || game_clr !== 1'b1 || countdown !== 2'd0) begin
         tests_failed++;
         $display("FAIL abort_ready: state=%0d clr=%0d cd=%0d, want 0 1 0", state, game_clr, countdown);
      end
      step(3);
      tests_run++;
      if (state !== 3'd0 || tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_stays_idle: state=%0d tick=%0d, want 0 0", state, tick);
      end
   endtask

   initial begin
      test_reset();
      test_countdown_run();
      test_pause_resume();
      test_record();
      test_reset_in_pause();
      test_held_start();
      test_abort_ready();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
